ppwm_sequencer: RTL

Instruction sequencer for the programmable PWM core. It fetches 8-bit commands from an external program memory, decodes them against the team's command set (CTRL, SET, ARITH, SHIFT, JUMP, CMP, BRANCH), and executes them. Execution updates the PWM compare value, a scratch register and a condition flag, and the block produces the registered PWM output against the free-running global counter. It sits between the program store and the pin driver and is the only writer of the PWM value.

---
 rtl/ppwm_sequencer.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/ppwm_sequencer.sv
// ppwm_sequencer: fetch/decode/execute sequencer that owns the PWM compare value.
// Build option: define PPWM_ARITH_SAT_EN to make ARITH saturate instead of wrap.
//   state   | meaning
//   S_IDLE  | stopped, waiting for run_i
//   S_FETCH | requesting the word at PC
//   S_EXEC  | executing the latched word, commits results and PC
//   S_WAIT  | parked until the global counter returns to zero
//   S_ERR   | illegal word seen, held until reset
module ppwm_sequencer #(
    parameter  int PROG_DEPTH = 16,
    parameter  int DATA_W     = 8,
    localparam int AW         = $clog2(PROG_DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              run_i,
    output logic              instr_req_o,
    output logic [AW-1:0]     instr_addr_o,
    input  logic              instr_valid_i,
    input  logic [7:0]        instr_i,
    input  logic [DATA_W-1:0] gcnt_i,
    output logic [DATA_W-1:0] pwm_val_o,
    output logic [DATA_W-1:0] reg_o,
    output logic              flag_o,
    output logic              busy_o,
    output logic              err_o,
    output logic              pwm_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_EXEC, S_WAIT, S_ERR
    } state_e;

    typedef enum logic [2:0] {
        C_CTRL   = 3'd0,
        C_SET    = 3'd1,
        C_ARITH  = 3'd2,
        C_SHIFT  = 3'd3,
        C_RSRV   = 3'd4,
        C_JUMP   = 3'd5,
        C_CMP    = 3'd6,
        C_BRANCH = 3'd7
    } cmd_e;

    state_e            state_q, state_d;
    logic [AW-1:0]     pc_q, pc_d;
    logic [7:0]        instr_q, instr_d;
    logic [DATA_W-1:0] pwm_val_q, pwm_val_d;
    logic [DATA_W-1:0] reg_q, reg_d;
    logic              flag_q, flag_d;
    logic              err_q, err_d;
    logic              pwm_q;

    cmd_e              cmd;
    logic              tgt;
    logic [3:0]        imm;
    logic signed [3:0] imm_s;
    logic signed [4:0] off5;
    logic [AW-1:0]     pc_inc, pc_off;
    logic [DATA_W-1:0] tgt_val, set_res, arith_res, shift_res;
    logic              cmp_ok, cmp_res;

    assign cmd    = cmd_e'(instr_q[7:5]);
    assign tgt    = instr_q[4];
    assign imm    = instr_q[3:0];
    assign imm_s  = instr_q[3:0];
    assign off5   = instr_q[4:0];
    assign pc_inc = pc_q + AW'(1);
    assign pc_off = pc_q + AW'(off5);

    assign tgt_val   = tgt ? reg_q : pwm_val_q;
    assign set_res   = {tgt_val[DATA_W-5:0], imm};
    assign shift_res = imm[3] ? (tgt_val >> imm[2:0]) : (tgt_val << imm[2:0]);

`ifdef PPWM_ARITH_SAT_EN
    // Two guard bits: bit DATA_W+1 flags a negative result, bit DATA_W an overflow.
    logic [DATA_W+1:0] sum_w;
    assign sum_w     = {2'b00, tgt_val} + (DATA_W+2)'(imm_s);
    assign arith_res = sum_w[DATA_W+1] ? '0 :
                       sum_w[DATA_W]   ? '1 : sum_w[DATA_W-1:0];
`else
    assign arith_res = tgt_val + DATA_W'(imm_s);
`endif

    always_comb begin
        cmp_ok  = 1'b1;
        cmp_res = 1'b0;
        case (imm[2:0])
            3'b000:  cmp_res = (gcnt_i <  pwm_val_q);
            3'b100:  cmp_res = (gcnt_i >= pwm_val_q);
            3'b001:  cmp_res = (gcnt_i <  reg_q);
            3'b101:  cmp_res = (gcnt_i >= reg_q);
            3'b010:  cmp_res = (pwm_val_q == reg_q);
            default: cmp_ok  = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        pwm_val_d   = pwm_val_q;
        reg_d       = reg_q;
        flag_d      = flag_q;
        err_d       = err_q;
        instr_req_o = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (run_i) begin
                    state_d = S_FETCH;
                    pc_d    = '0;
                end
            end
            S_FETCH: begin
                if (!run_i) begin
                    state_d = S_IDLE;
                end else begin
                    instr_req_o = 1'b1;
                    if (instr_valid_i) begin
                        instr_d = instr_i;
                        state_d = S_EXEC;
                    end
                end
            end
            S_EXEC: begin
                state_d = S_FETCH;
                pc_d    = pc_inc;
                case (cmd)
                    C_CTRL: begin
                        if (imm[1:0] == 2'b01) begin
                            state_d = S_IDLE;
                        end else if (imm[1:0] == 2'b10) begin
                            state_d = S_WAIT;
                            pc_d    = pc_q;
                        end
                    end
                    C_SET, C_ARITH, C_SHIFT: begin
                        if (tgt) begin
                            reg_d = (cmd == C_SET) ? set_res : (cmd == C_ARITH) ? arith_res : shift_res;
                        end else begin
                            pwm_val_d = (cmd == C_SET) ? set_res : (cmd == C_ARITH) ? arith_res : shift_res;
                        end
                    end
                    C_JUMP: pc_d = pc_off;
                    C_CMP: begin
                        if (cmp_ok) begin
                            flag_d = cmp_res;
                        end else begin
                            err_d   = 1'b1;
                            state_d = S_ERR;
                            pc_d    = pc_q;
                        end
                    end
                    C_BRANCH: begin
                        if (flag_q) pc_d = pc_off;
                    end
                    default: begin
                        err_d   = 1'b1;
                        state_d = S_ERR;
                        pc_d    = pc_q;
                    end
                endcase
            end
            S_WAIT: begin
                if (!run_i) begin
                    state_d = S_IDLE;
                end else if (gcnt_i == '0) begin
                    state_d = S_FETCH;
                    pc_d    = pc_inc;
                end
            end
            S_ERR:   state_d = S_ERR;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            pc_q      <= '0;
            instr_q   <= '0;
            pwm_val_q <= '0;
            reg_q     <= '0;
            flag_q    <= 1'b0;
            err_q     <= 1'b0;
            pwm_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            pwm_val_q <= pwm_val_d;
            reg_q     <= reg_d;
            flag_q    <= flag_d;
            err_q     <= err_d;
            pwm_q     <= (gcnt_i < pwm_val_q);
        end
    end

    assign instr_addr_o = pc_q;
    assign pwm_val_o    = pwm_val_q;
    assign reg_o        = reg_q;
    assign flag_o       = flag_q;
    assign busy_o       = (state_q != S_IDLE);
    assign err_o        = err_q;
    assign pwm_o        = pwm_q;

endmodule
